// File: rtl/vending_controller.sv
// Multi-item coin vending controller: credit accumulation, per-item pricing and coin-by-coin change payout.
// Optional per-item stock counting is enabled by defining VENDING_STOCK_COUNT_EN.
module vending_controller #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 8,
  parameter int CREDIT_MAX = 100,
  parameter int COIN0_VAL  = 5,
  parameter int COIN1_VAL  = 10,
  parameter int COIN2_VAL  = 20,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           coin_in,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel_item,
  input  logic                 cancel,
  input  logic                 chg_ack,
  input  logic                 restock,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend,
  output logic [SEL_W-1:0]     vend_item,
  output logic                 deny,
  output logic                 coin_reject,
  output logic [2:0]           chg_coin,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] C0   = CREDIT_W'(COIN0_VAL);
  localparam logic [CREDIT_W-1:0] C1   = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2   = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W:0]   CMAX = (CREDIT_W+1)'(CREDIT_MAX);

  state_t               state, state_nx;
  logic [CREDIT_W-1:0]  credit_nx;
  logic                 vend_nx, deny_nx, coin_reject_nx;
  logic [SEL_W-1:0]     vend_item_nx;
  logic [2:0]           chg_coin_nx;
  logic [NUM_ITEMS-1:0] dec_item;
  logic                 reload;

  logic                 coin_legal;
  logic [CREDIT_W:0]    coin_sum;
  logic                 sel_in_range;
  logic [SEL_W-1:0]     sel_idx;
  logic [CREDIT_W-1:0]  price;
  logic                 item_sold_out;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] c);
    case (c)
      3'b001:  return C0;
      3'b010:  return C1;
      3'b100:  return C2;
      default: return '0;
    endcase
  endfunction

  // Greedy choice: the largest single coin that does not exceed the remaining credit.
  function automatic logic [2:0] largest_coin(input logic [CREDIT_W-1:0] c);
    if (c >= C2)      return 3'b100;
    else if (c >= C1) return 3'b010;
    else if (c >= C0) return 3'b001;
    else              return 3'b000;
  endfunction

  assign coin_legal    = $onehot(coin_in);
  assign coin_sum      = {1'b0, credit} + {1'b0, coin_value(coin_in)};
  assign sel_in_range  = 32'(sel_item) < NUM_ITEMS;
  assign sel_idx       = sel_in_range ? sel_item : '0;
  assign price         = PRICE_LIST[32'(sel_idx)*CREDIT_W +: CREDIT_W];
  assign item_sold_out = sold_out[sel_idx];

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx       = state;
    credit_nx      = credit;
    vend_nx        = 1'b0;
    vend_item_nx   = '0;
    deny_nx        = 1'b0;
    coin_reject_nx = 1'b0;
    chg_coin_nx    = chg_coin;
    dec_item       = '0;
    reload         = 1'b0;

    case (state)
      S_IDLE, S_CREDIT: begin
        chg_coin_nx = '0;
        reload      = restock;
        if (coin_in != 3'b000 && (cancel || sel_valid || !coin_legal || coin_sum > CMAX))
          coin_reject_nx = 1'b1;

        // cancel owns the cycle even with zero credit, so a simultaneous request is dropped.
        if (cancel) begin
          if (credit != '0) begin
            state_nx    = S_CHANGE;
            chg_coin_nx = largest_coin(credit);
          end
        end else if (sel_valid) begin
          if (!sel_in_range || credit < price || item_sold_out) begin
            deny_nx = 1'b1;
          end else begin
            vend_nx           = 1'b1;
            vend_item_nx      = sel_item;
            credit_nx         = credit - price;
            dec_item[sel_idx] = 1'b1;
            if (credit_nx != '0) begin
              state_nx    = S_CHANGE;
              chg_coin_nx = largest_coin(credit_nx);
            end else begin
              state_nx = S_IDLE;
            end
          end
        end else if (coin_in != 3'b000 && !coin_reject_nx) begin
          credit_nx = coin_sum[CREDIT_W-1:0];
          state_nx  = S_CREDIT;
        end
      end

      S_CHANGE: begin
        coin_reject_nx = (coin_in != 3'b000);
        if (chg_coin == 3'b000) begin
          // Entered with a residual smaller than any coin: forfeit it.
          credit_nx = '0;
          state_nx  = S_IDLE;
        end else if (chg_ack) begin
          credit_nx   = credit - coin_value(chg_coin);
          chg_coin_nx = largest_coin(credit_nx);
          if (chg_coin_nx == 3'b000) begin
            credit_nx = '0;
            state_nx  = S_IDLE;
          end
        end
      end

      default: begin
        state_nx    = S_IDLE;
        credit_nx   = '0;
        chg_coin_nx = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
      chg_coin    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      vend        <= vend_nx;
      vend_item   <= vend_item_nx;
      deny        <= deny_nx;
      coin_reject <= coin_reject_nx;
      chg_coin    <= chg_coin_nx;
      busy        <= (state_nx == S_CHANGE);
    end
  end

`ifdef VENDING_STOCK_COUNT_EN
  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  // NOTE: the stock array is reset because its reload value is architectural state, not scratch storage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (rst || reload)
        stock[k] <= STOCK_W'(STOCK_INIT);
      else if (dec_item[k] && stock[k] != '0)
        stock[k] <= stock[k] - 1'b1;
    end
  end

  always_comb begin
    sold_out = '0;
    for (int k = 0; k < NUM_ITEMS; k++)
      sold_out[k] = (stock[k] == '0);
  end
`else
  logic unused_stock;

  assign sold_out     = '0;
  assign unused_stock = ^{reload, dec_item, STOCK_W[0], STOCK_INIT[0]};
`endif

endmodule

// File: tb/tb_vending_controller.sv
// Randomised self-checking bench for vending_controller against a queue-based payout model.
// Define VENDING_STOCK_COUNT_EN for both files to exercise stock counting (STOCK_INIT=1 here).
module tb_vending_controller;

`ifdef VENDING_STOCK_COUNT_EN
  localparam int TB_STOCK_INIT = 1;
`else
  localparam int TB_STOCK_INIT = 10;
`endif
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] coin_in = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       chg_ack = 1'b0;
  logic       restock = 1'b0;
  logic [7:0] credit;
  logic       vend;
  logic [1:0] vend_item;
  logic       deny;
  logic       coin_reject;
  logic [2:0] chg_coin;
  logic       busy;
  logic [3:0] sold_out;

  int checks = 0;
  int errors = 0;

  vending_controller #(.STOCK_INIT(TB_STOCK_INIT)) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .chg_ack(chg_ack), .restock(restock), .credit(credit), .vend(vend),
    .vend_item(vend_item), .deny(deny), .coin_reject(coin_reject), .chg_coin(chg_coin),
    .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: credit as an integer, pending change as a queue of coin values.
  int price_tab [N] = '{15, 20, 25, 30};
  int m_credit;
  int m_change[$];
  int m_stock [N];
  bit e_vend, e_deny, e_rej;
  int e_item;

  function automatic int coin_val(input logic [2:0] c);
    if (c == 3'b001) return 5;
    if (c == 3'b010) return 10;
    if (c == 3'b100) return 20;
    return 0;
  endfunction

  function automatic logic [2:0] coin_code(input int v);
    if (v == 20) return 3'b100;
    if (v == 10) return 3'b010;
    if (v == 5)  return 3'b001;
    return 3'b000;
  endfunction

  function automatic void make_change();
    int r = m_credit;
    while (r >= 20) begin m_change.push_back(20); r -= 20; end
    while (r >= 10) begin m_change.push_back(10); r -= 10; end
    while (r >= 5)  begin m_change.push_back(5);  r -= 5;  end
    if (m_change.size() == 0) m_credit = 0;
  endfunction

  function automatic void model_step(input bit r, input logic [2:0] c, input bit s, input int it,
                                     input bit can, input bit ack, input bit rs);
    int  v;
    bit  sold;
    e_vend = 0; e_deny = 0; e_rej = 0; e_item = 0;
    if (r) begin
      m_credit = 0;
      m_change.delete();
      for (int k = 0; k < N; k++) m_stock[k] = TB_STOCK_INIT;
      return;
    end
    if (m_change.size() > 0) begin
      e_rej = (c != 3'b000);
      if (ack) begin
        m_credit -= m_change.pop_front();
        if (m_change.size() == 0) m_credit = 0;
      end
      return;
    end
    v = coin_val(c);
    if (c != 3'b000 && (can || s || $countones(c) != 1 || m_credit + v > 100)) e_rej = 1;
`ifdef VENDING_STOCK_COUNT_EN
    sold = (m_stock[it] == 0);
`else
    sold = 0;
`endif
    if (can) begin
      if (m_credit > 0) make_change();
    end else if (s) begin
      if (it >= N || m_credit < price_tab[it] || sold) e_deny = 1;
      else begin
        e_vend = 1;
        e_item = it;
        m_credit -= price_tab[it];
        m_stock[it]--;
        if (m_credit > 0) make_change();
      end
    end else if (c != 3'b000 && !e_rej) begin
      m_credit += v;
    end
    if (rs) for (int k = 0; k < N; k++) m_stock[k] = TB_STOCK_INIT;
  endfunction

  task automatic compare_all();
    logic [3:0] e_sold = '0;
`ifdef VENDING_STOCK_COUNT_EN
    for (int k = 0; k < N; k++) e_sold[k] = (m_stock[k] == 0);
`endif
    check("credit", credit, m_credit);
    check("vend", vend, e_vend);
    check("vend_item", vend_item, e_vend ? e_item : 0);
    check("deny", deny, e_deny);
    check("coin_reject", coin_reject, e_rej);
    check("chg_coin", chg_coin, m_change.size() > 0 ? coin_code(m_change[0]) : 3'b000);
    check("busy", busy, m_change.size() > 0);
    check("sold_out", sold_out, e_sold);
  endtask

  task automatic step(input bit r, input logic [2:0] c, input bit s, input logic [1:0] it,
                      input bit can, input bit ack, input bit rs);
    rst = r; coin_in = c; sel_valid = s; sel_item = it; cancel = can; chg_ack = ack; restock = rs;
    @(posedge clk);
    #1;
    model_step(r, c, s, int'(it), can, ack, rs);
    rst = 0; coin_in = '0; sel_valid = 0; cancel = 0; chg_ack = 0; restock = 0;
    compare_all();
  endtask

  task automatic coin(input logic [2:0] c);
    step(0, c, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step(0, 3'b000, 0, 2'd0, 0, 1, 0);
    check("drain_done", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 3'b000, 0, 2'd0, 0, 0, 0);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_chg", chg_coin, 0);

    // Single 20 coin, buy item 0 (15), pay back one 5.
    coin(3'b100);
    check("t1_credit", credit, 20);
    step(0, 3'b000, 1, 2'd0, 0, 0, 0);
    check("t1_vend", vend, 1);
    check("t1_credit5", credit, 5);
    check("t1_chg", chg_coin, 3'b001);
    step(0, 3'b000, 0, 2'd0, 0, 0, 0);
    check("t1_hold", chg_coin, 3'b001);
    step(0, 3'b000, 0, 2'd0, 0, 1, 0);
    check("t1_done", credit, 0);

    // 15 credit, item 3 too expensive, cancel pays 10 then 5.
    coin(3'b001);
    coin(3'b010);
    step(0, 3'b000, 1, 2'd3, 0, 0, 0);
    check("t2_deny", deny, 1);
    check("t2_credit", credit, 15);
    step(0, 3'b000, 0, 2'd0, 1, 0, 0);
    check("t2_chg10", chg_coin, 3'b010);
    step(0, 3'b000, 0, 2'd0, 0, 1, 0);
    check("t2_chg5", chg_coin, 3'b001);
    step(0, 3'b000, 0, 2'd0, 0, 1, 0);
    check("t2_zero", credit, 0);

    // Multi-hot reject, fill to the ceiling, then overflow reject.
    coin(3'b011);
    check("t3_multihot", coin_reject, 1);
    for (int i = 0; i < 5; i++) coin(3'b100);
    check("t3_full", credit, 100);
    coin(3'b001);
    check("t3_overflow", coin_reject, 1);
    check("t3_keep", credit, 100);
    step(0, 3'b000, 0, 2'd0, 1, 0, 0);
    drain();

    // cancel + sel + coin in one cycle: coin rejected, cancel wins.
    coin(3'b010);
    step(0, 3'b001, 1, 2'd0, 1, 0, 0);
    check("t4_reject", coin_reject, 1);
    check("t4_novend", vend, 0);
    check("t4_busy", busy, 1);
    check("t4_credit", credit, 10);
    drain();

    // Reset while a change coin is held.
    coin(3'b010);
    step(0, 3'b000, 0, 2'd0, 1, 0, 0);
    check("t5_held", chg_coin, 3'b010);
    step(1, 3'b000, 0, 2'd0, 0, 0, 0);
    check("t5_chg", chg_coin, 0);
    check("t5_busy", busy, 0);
    check("t5_credit", credit, 0);

`ifdef VENDING_STOCK_COUNT_EN
    coin(3'b100);
    coin(3'b100);
    step(0, 3'b000, 1, 2'd1, 0, 0, 0);
    check("t6_vend", vend, 1);
    drain();
    coin(3'b100);
    step(0, 3'b000, 1, 2'd1, 0, 0, 0);
    check("t6_deny", deny, 1);
    check("t6_sold", sold_out, 4'b0010);
    step(0, 3'b000, 0, 2'd0, 0, 0, 1);
    check("t6_restock", sold_out, 4'b0000);
    step(0, 3'b000, 0, 2'd0, 1, 0, 0);
    drain();
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] c;
      bit s, can, ack, r, rs;
      int pick;
      c    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 9);
      can  = (pick == 0);
      s    = (pick >= 7);
      ack  = ($urandom_range(0, 2) == 0);
      rs   = ($urandom_range(0, 19) == 0);
      r    = ($urandom_range(0, 127) == 0);
      step(r, c, s, 2'($urandom_range(0, 3)), can, ack, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
